// File: rtl/ins_loader_if.sv
// Byte-stream loader bus: control/stream inputs toward the loader, memory/CPU-side outputs back.
// Signal prefixes are from the loader's point of view (i_ into the loader, o_ out of it).
interface ins_loader_if;
    logic        i_start;
    logic        i_abort;
    logic [7:0]  i_byte_in;
    logic        i_byte_valid;
    logic        o_byte_ready;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_data;
    logic [31:0] o_pc_value;
    logic        o_cpu_hold;
    logic        o_busy;
    logic        o_done;
    logic        o_err;

    modport master (
        output i_start, i_abort, i_byte_in, i_byte_valid,
        input  o_byte_ready, o_mem_we, o_mem_addr, o_mem_data, o_pc_value,
        input  o_cpu_hold, o_busy, o_done, o_err
    );

    modport slave (
        input  i_start, i_abort, i_byte_in, i_byte_valid,
        output o_byte_ready, o_mem_we, o_mem_addr, o_mem_data, o_pc_value,
        output o_cpu_hold, o_busy, o_done, o_err
    );
endinterface

// File: rtl/ins_loader.sv
// Instruction loader: parses a big-endian byte stream (address, word count, words)
// and writes the words into CPU instruction memory while holding the CPU in reset.
module ins_loader #(
    parameter int unsigned WORDS_MAX = 64
) (
    input  logic         i_clk,
    input  logic         i_rst,
    ins_loader_if.slave  bus
);
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 16;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_HDR_ADDR = 3'd1,
        S_HDR_CNT  = 3'd2,
        S_PAYLOAD  = 3'd3,
        S_WRITE    = 3'd4,
        S_DONE     = 3'd5,
        S_ERR      = 3'd6
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [1:0]      r_byte_cnt;
    logic [AW-1:0]   r_addr;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   r_word_idx;
    logic [DW-1:0]   r_asm;
    logic [AW-1:0]   r_wr_addr;

    logic            r_byte_ready;
    logic            r_mem_we;
    logic [AW-1:0]   r_mem_addr;
    logic [DW-1:0]   r_mem_data;
    logic [AW-1:0]   r_pc_value;
    logic            r_cpu_hold;
    logic            r_busy;
    logic            r_done;
    logic            r_err;

    logic            w_ready;
    logic            w_accept;
    logic            w_session_start;
    logic [AW-1:0]   w_addr_shift;
    logic [CW-1:0]   w_cnt_shift;
    logic [DW-1:0]   w_asm_shift;
    logic            w_addr_bad;
    logic            w_cnt_bad;
    logic            w_more;

    logic            w_byte_ready_nxt;
    logic            w_mem_we_nxt;
    logic            w_cpu_hold_nxt;
    logic            w_busy_nxt;
    logic            w_done_nxt;
    logic            w_err_nxt;

    assign w_ready         = (r_state == S_HDR_ADDR) || (r_state == S_HDR_CNT) ||
                             (r_state == S_PAYLOAD);
    assign w_accept        = w_ready && bus.i_byte_valid;
    assign w_addr_shift    = {r_addr[AW-9:0], bus.i_byte_in};
    assign w_cnt_shift     = {r_cnt[CW-9:0], bus.i_byte_in};
    assign w_asm_shift     = {r_asm[DW-9:0], bus.i_byte_in};
    assign w_addr_bad      = (w_addr_shift[1:0] != 2'b00);
    assign w_cnt_bad       = (w_cnt_shift == CW'(0)) || (32'(w_cnt_shift) > WORDS_MAX);
    assign w_more          = ((17'(r_word_idx) + 17'd1) < 17'(r_cnt));
    assign w_session_start = ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR)) &&
                             (w_state_nxt == S_HDR_ADDR);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; abort outranks everything except reset
    always_comb begin
        w_state_nxt = r_state;
        if (bus.i_abort && (r_state != S_IDLE)) begin
            w_state_nxt = S_ERR;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (bus.i_start) w_state_nxt = S_HDR_ADDR;
                end
                S_HDR_ADDR: begin
                    if (w_accept && (r_byte_cnt == 2'd3))
                        w_state_nxt = w_addr_bad ? S_ERR : S_HDR_CNT;
                end
                S_HDR_CNT: begin
                    if (w_accept && (r_byte_cnt == 2'd1))
                        w_state_nxt = w_cnt_bad ? S_ERR : S_PAYLOAD;
                end
                S_PAYLOAD: begin
                    if (w_accept && (r_byte_cnt == 2'd3)) w_state_nxt = S_WRITE;
                end
                S_WRITE: begin
                    w_state_nxt = w_more ? S_PAYLOAD : S_DONE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Output decode of the upcoming state, registered below so outputs track the state
    always_comb begin
        w_byte_ready_nxt = 1'b0;
        w_mem_we_nxt     = 1'b0;
        w_cpu_hold_nxt   = 1'b1;
        w_busy_nxt       = 1'b0;
        w_done_nxt       = 1'b0;
        w_err_nxt        = 1'b0;
        case (w_state_nxt)
            S_HDR_ADDR, S_HDR_CNT, S_PAYLOAD: begin
                w_byte_ready_nxt = 1'b1;
                w_busy_nxt       = 1'b1;
            end
            S_WRITE: begin
                w_mem_we_nxt = 1'b1;
                w_busy_nxt   = 1'b1;
            end
            S_DONE: begin
                w_done_nxt     = 1'b1;
                w_cpu_hold_nxt = 1'b0;
            end
            S_ERR:   w_err_nxt = 1'b1;
            default: ;
        endcase
    end

    // Datapath: header capture, word assembly, write address stepping, output registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_byte_cnt   <= 2'd0;
            r_addr       <= '0;
            r_cnt        <= '0;
            r_word_idx   <= '0;
            r_asm        <= '0;
            r_wr_addr    <= '0;
            r_byte_ready <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_data   <= '0;
            r_pc_value   <= '0;
            r_cpu_hold   <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_byte_ready <= w_byte_ready_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_cpu_hold   <= w_cpu_hold_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_err        <= w_err_nxt;

            if (w_session_start) begin
                r_byte_cnt <= 2'd0;
                r_addr     <= '0;
                r_cnt      <= '0;
                r_word_idx <= '0;
                r_asm      <= '0;
                r_wr_addr  <= '0;
            end else begin
                case (r_state)
                    S_HDR_ADDR: begin
                        if (w_accept) begin
                            r_addr     <= w_addr_shift;
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                        end
                        // PC only follows a header address that passed the alignment check
                        if (w_state_nxt == S_HDR_CNT) begin
                            r_pc_value <= w_addr_shift;
                            r_wr_addr  <= w_addr_shift;
                            r_byte_cnt <= 2'd0;
                        end
                    end
                    S_HDR_CNT: begin
                        if (w_accept) begin
                            r_cnt      <= w_cnt_shift;
                            r_byte_cnt <= (r_byte_cnt == 2'd1) ? 2'd0 : r_byte_cnt + 2'd1;
                        end
                    end
                    S_PAYLOAD: begin
                        if (w_accept) begin
                            r_asm      <= w_asm_shift;
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                        end
                        if (w_state_nxt == S_WRITE) begin
                            r_mem_data <= w_asm_shift;
                            r_mem_addr <= r_wr_addr;
                        end
                    end
                    S_WRITE: begin
                        r_word_idx <= r_word_idx + CW'(1);
                        r_wr_addr  <= r_wr_addr + AW'(4);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.o_byte_ready = r_byte_ready;
    assign bus.o_mem_we     = r_mem_we;
    assign bus.o_mem_addr   = r_mem_addr;
    assign bus.o_mem_data   = r_mem_data;
    assign bus.o_pc_value   = r_pc_value;
    assign bus.o_cpu_hold   = r_cpu_hold;
    assign bus.o_busy       = r_busy;
    assign bus.o_done       = r_done;
    assign bus.o_err        = r_err;

endmodule

// File: tb/tb_ins_loader.sv
// Directed bench for ins_loader: nominal load, back-pressure, header errors,
// abort, mid-session reset and address wrap, with hand-computed expectations.
module tb_ins_loader;
    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    logic [63:0] wq[$];
    logic        bp_viol;

    ins_loader_if bus ();

    ins_loader #(.WORDS_MAX(64)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor sampled mid-cycle
    always @(negedge clk) begin
        if (bus.o_mem_we === 1'b1) begin
            wq.push_back({bus.o_mem_addr, bus.o_mem_data});
            if (bus.o_byte_ready !== 1'b0) bp_viol = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
    endtask

    // Offer one byte and wait for the edge that consumes it; keep_valid leaves valid high
    task automatic send_byte(input logic [7:0] b, input bit keep_valid);
        int n;
        n = 0;
        bus.i_byte_in    = b;
        bus.i_byte_valid = 1'b1;
        while (bus.o_byte_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) begin
            n_assert++;
            n_fail++;
            $display("FAIL send_byte_timeout: byte %h never accepted, ready=%b", b, bus.o_byte_ready);
        end
        step();
        if (!keep_valid) bus.i_byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit keep_valid);
        send_byte(w[31:24], keep_valid);
        send_byte(w[23:16], keep_valid);
        send_byte(w[15:8],  keep_valid);
        send_byte(w[7:0],   keep_valid);
    endtask

    task automatic send_hdr(input logic [31:0] a, input logic [15:0] n, input bit keep_valid);
        send_word(a, keep_valid);
        send_byte(n[15:8], keep_valid);
        send_byte(n[7:0],  keep_valid);
    endtask

    task automatic wait_end(input string name);
        int n;
        n = 0;
        while (bus.o_done !== 1'b1 && bus.o_err !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) begin
            n_assert++;
            n_fail++;
            $display("FAIL %s_timeout: done=%b err=%b after %0d cycles", name, bus.o_done, bus.o_err, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_assert++;
        if ({bus.o_byte_ready, bus.o_mem_we, bus.o_cpu_hold, bus.o_busy, bus.o_done, bus.o_err} !== 6'b001000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 001000",
                     {bus.o_byte_ready, bus.o_mem_we, bus.o_cpu_hold, bus.o_busy, bus.o_done, bus.o_err});
        end
        n_assert++;
        if ({bus.o_mem_addr, bus.o_mem_data, bus.o_pc_value} !== 96'd0) begin
            n_fail++;
            $display("FAIL reset_values: addr=%h data=%h pc=%h expected zeros",
                     bus.o_mem_addr, bus.o_mem_data, bus.o_pc_value);
        end
        rst = 1'b0;
        step();
        n_assert++;
        if (bus.o_byte_ready !== 1'b0 || bus.o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_flags: ready=%b busy=%b expected 0 0", bus.o_byte_ready, bus.o_busy);
        end
    endtask

    task automatic test_nominal();
        wq.delete();
        pulse_start();
        n_assert++;
        if (bus.o_busy !== 1'b1 || bus.o_byte_ready !== 1'b1 || bus.o_cpu_hold !== 1'b1) begin
            n_fail++;
            $display("FAIL nominal_start: busy=%b ready=%b hold=%b expected 1 1 1",
                     bus.o_busy, bus.o_byte_ready, bus.o_cpu_hold);
        end
        send_word(32'h0000_0100, 1'b0);
        n_assert++;
        if (bus.o_pc_value !== 32'h100) begin
            n_fail++;
            $display("FAIL nominal_pc: got %h expected 00000100", bus.o_pc_value);
        end
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_word(32'h0200_0008, 1'b0);
        n_assert++;
        if (bus.o_mem_we !== 1'b1 || bus.o_mem_addr !== 32'h100 || bus.o_mem_data !== 32'h0200_0008
            || bus.o_byte_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL nominal_write0: we=%b addr=%h data=%h ready=%b expected 1 00000100 02000008 0",
                     bus.o_mem_we, bus.o_mem_addr, bus.o_mem_data, bus.o_byte_ready);
        end
        send_word(32'h0000_0000, 1'b0);
        n_assert++;
        if (bus.o_mem_we !== 1'b1 || bus.o_mem_addr !== 32'h104 || bus.o_mem_data !== 32'h0) begin
            n_fail++;
            $display("FAIL nominal_write1: we=%b addr=%h data=%h expected 1 00000104 00000000",
                     bus.o_mem_we, bus.o_mem_addr, bus.o_mem_data);
        end
        step();
        n_assert++;
        if ({bus.o_done, bus.o_cpu_hold, bus.o_busy, bus.o_mem_we, bus.o_err} !== 5'b10000
            || bus.o_mem_addr !== 32'h104) begin
            n_fail++;
            $display("FAIL nominal_done: done/hold/busy/we/err=%b addr=%h expected 10000 00000104",
                     {bus.o_done, bus.o_cpu_hold, bus.o_busy, bus.o_mem_we, bus.o_err}, bus.o_mem_addr);
        end
        n_assert++;
        if (wq.size() != 2) begin
            n_fail++;
            $display("FAIL nominal_count: got %0d writes expected 2", wq.size());
        end
    endtask

    task automatic test_back_pressure();
        wq.delete();
        bp_viol = 1'b0;
        pulse_start();
        send_hdr(32'h0000_0200, 16'd3, 1'b1);
        send_word(32'h1122_3344, 1'b1);
        send_word(32'h5566_7788, 1'b1);
        send_word(32'h99AA_BBCC, 1'b1);
        bus.i_byte_in = 8'hEE;
        wait_end("bp");
        bus.i_byte_valid = 1'b0;
        n_assert++;
        if (bp_viol !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_ready_in_write: ready seen high during write");
        end
        n_assert++;
        if (wq.size() != 3) begin
            n_fail++;
            $display("FAIL bp_count: got %0d writes expected 3", wq.size());
        end else begin
            n_assert++;
            if (wq[0] !== 64'h0000_0200_1122_3344 || wq[1] !== 64'h0000_0204_5566_7788
                || wq[2] !== 64'h0000_0208_99AA_BBCC) begin
                n_fail++;
                $display("FAIL bp_data: got %h %h %h expected 0000020011223344 0000020455667788 0000020899aabbcc",
                         wq[0], wq[1], wq[2]);
            end
        end
        n_assert++;
        if (bus.o_done !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_done: got %b expected 1", bus.o_done);
        end
    endtask

    task automatic test_hdr_errors();
        wq.delete();
        pulse_start();
        send_word(32'h0000_0102, 1'b0);
        n_assert++;
        if ({bus.o_err, bus.o_cpu_hold, bus.o_done, bus.o_busy, bus.o_byte_ready} !== 5'b11000) begin
            n_fail++;
            $display("FAIL err_align: err/hold/done/busy/ready=%b expected 11000",
                     {bus.o_err, bus.o_cpu_hold, bus.o_done, bus.o_busy, bus.o_byte_ready});
        end
        pulse_start();
        send_hdr(32'h0000_0100, 16'd0, 1'b0);
        n_assert++;
        if (bus.o_err !== 1'b1 || bus.o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL err_cnt_zero: err=%b busy=%b expected 1 0", bus.o_err, bus.o_busy);
        end
        pulse_start();
        send_hdr(32'h0000_0100, 16'h0041, 1'b0);
        n_assert++;
        if (bus.o_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_cnt_over: err=%b expected 1", bus.o_err);
        end
        pulse_start();
        send_hdr(32'h0000_0100, 16'h0040, 1'b0);
        n_assert++;
        if (bus.o_err !== 1'b0 || bus.o_busy !== 1'b1 || bus.o_byte_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL cnt_max_ok: err=%b busy=%b ready=%b expected 0 1 1",
                     bus.o_err, bus.o_busy, bus.o_byte_ready);
        end
        bus.i_abort = 1'b1;
        step();
        bus.i_abort = 1'b0;
        n_assert++;
        if (wq.size() != 0) begin
            n_fail++;
            $display("FAIL err_no_write: got %0d writes expected 0", wq.size());
        end
    endtask

    task automatic test_abort();
        wq.delete();
        pulse_start();
        send_hdr(32'h0000_0100, 16'd1, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        bus.i_byte_in    = 8'hCC;
        bus.i_byte_valid = 1'b1;
        bus.i_abort      = 1'b1;
        step();
        bus.i_abort      = 1'b0;
        bus.i_byte_valid = 1'b0;
        n_assert++;
        if ({bus.o_err, bus.o_cpu_hold, bus.o_busy} !== 3'b110) begin
            n_fail++;
            $display("FAIL abort_payload: err/hold/busy=%b expected 110", {bus.o_err, bus.o_cpu_hold, bus.o_busy});
        end
        bus.i_byte_in    = 8'hDD;
        bus.i_byte_valid = 1'b1;
        repeat (4) step();
        bus.i_byte_valid = 1'b0;
        n_assert++;
        if (wq.size() != 0 || bus.o_err !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_quiet: writes=%0d err=%b expected 0 1", wq.size(), bus.o_err);
        end
        pulse_start();
        send_hdr(32'h0000_0040, 16'd1, 1'b0);
        send_word(32'hDEAD_BEEF, 1'b0);
        wait_end("abort_restart");
        n_assert++;
        if (bus.o_done !== 1'b1 || wq.size() != 1 || wq[0] !== 64'h0000_0040_DEAD_BEEF) begin
            n_fail++;
            $display("FAIL abort_restart: done=%b writes=%0d first=%h expected 1 1 00000040deadbeef",
                     bus.o_done, wq.size(), (wq.size() > 0) ? wq[0] : 64'h0);
        end
        // Start together with Abort in DONE: abort wins
        bus.i_start = 1'b1;
        bus.i_abort = 1'b1;
        step();
        bus.i_start = 1'b0;
        bus.i_abort = 1'b0;
        n_assert++;
        if (bus.o_err !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) begin
            n_fail++;
            $display("FAIL start_abort_done: err=%b busy=%b done=%b expected 1 0 0",
                     bus.o_err, bus.o_busy, bus.o_done);
        end
        // Abort arriving during the write cycle still lets the strobe complete
        wq.delete();
        pulse_start();
        send_hdr(32'h0000_0080, 16'd2, 1'b0);
        send_word(32'hCAFE_F00D, 1'b0);
        bus.i_abort = 1'b1;
        step();
        bus.i_abort = 1'b0;
        n_assert++;
        if (bus.o_err !== 1'b1 || wq.size() != 1 || wq[0] !== 64'h0000_0080_CAFE_F00D) begin
            n_fail++;
            $display("FAIL abort_write: err=%b writes=%0d first=%h expected 1 1 00000080cafef00d",
                     bus.o_err, wq.size(), (wq.size() > 0) ? wq[0] : 64'h0);
        end
    endtask

    task automatic test_reset_mid();
        wq.delete();
        pulse_start();
        send_hdr(32'h0000_0300, 16'd2, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        rst              = 1'b1;
        bus.i_start      = 1'b1;
        bus.i_abort      = 1'b1;
        bus.i_byte_valid = 1'b1;
        step();
        n_assert++;
        if ({bus.o_byte_ready, bus.o_mem_we, bus.o_cpu_hold, bus.o_busy, bus.o_done, bus.o_err} !== 6'b001000
            || bus.o_pc_value !== 32'h0 || bus.o_mem_addr !== 32'h0 || bus.o_mem_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid: flags=%b pc=%h addr=%h data=%h expected 001000 0 0 0",
                     {bus.o_byte_ready, bus.o_mem_we, bus.o_cpu_hold, bus.o_busy, bus.o_done, bus.o_err},
                     bus.o_pc_value, bus.o_mem_addr, bus.o_mem_data);
        end
        rst              = 1'b0;
        bus.i_start      = 1'b0;
        bus.i_abort      = 1'b0;
        bus.i_byte_valid = 1'b0;
        step();
        pulse_start();
        send_hdr(32'h0000_0010, 16'd1, 1'b0);
        send_word(32'h1234_5678, 1'b0);
        wait_end("reset_mid");
        n_assert++;
        if (bus.o_done !== 1'b1 || bus.o_pc_value !== 32'h10 || wq.size() != 1
            || wq[0] !== 64'h0000_0010_1234_5678) begin
            n_fail++;
            $display("FAIL reset_fresh: done=%b pc=%h writes=%0d expected 1 00000010 1",
                     bus.o_done, bus.o_pc_value, wq.size());
        end
    endtask

    task automatic test_wrap();
        wq.delete();
        pulse_start();
        send_word(32'hFFFF_FFFC, 1'b0);
        // Start during the count phase is ignored
        bus.i_start = 1'b1;
        send_byte(8'h00, 1'b0);
        bus.i_start = 1'b0;
        send_byte(8'h02, 1'b0);
        send_word(32'h0000_0001, 1'b0);
        send_word(32'h0000_0002, 1'b0);
        wait_end("wrap");
        n_assert++;
        if (wq.size() != 2) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d writes expected 2", wq.size());
        end else begin
            n_assert++;
            if (wq[0] !== 64'hFFFF_FFFC_0000_0001 || wq[1] !== 64'h0000_0000_0000_0002) begin
                n_fail++;
                $display("FAIL wrap_addr: got %h %h expected fffffffc00000001 0000000000000002", wq[0], wq[1]);
            end
        end
        n_assert++;
        if (bus.o_pc_value !== 32'hFFFF_FFFC || bus.o_done !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_pc: pc=%h done=%b expected fffffffc 1", bus.o_pc_value, bus.o_done);
        end
    endtask

    initial begin
        n_assert         = 0;
        n_fail           = 0;
        bp_viol          = 1'b0;
        rst              = 1'b1;
        bus.i_start      = 1'b0;
        bus.i_abort      = 1'b0;
        bus.i_byte_in    = 8'h00;
        bus.i_byte_valid = 1'b0;
        test_reset();
        test_nominal();
        test_back_pressure();
        test_hdr_errors();
        test_abort();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/ins_loader.md
INS_LOADER -- requirements
Module: ins_loader

Interface
REQ-001 SHALL have parameter WORDS_MAX, default 64: maximum instruction words per load.
REQ-002 SHALL have one clock and a synchronous, active-high reset: CLK  input  1  sole clock, all state updates on rising edge.
REQ-003 RST  input  1  synchronous active-high reset.
REQ-004 Start  input  1  single-cycle pulse, begins a load session.
REQ-005 Abort  input  1  terminates the current session.
REQ-006 ByteIn  input  8  loader stream byte.
REQ-007 ByteValid  input  1  ByteIn valid.
REQ-008 ByteReady  output  1  loader accepts ByteIn this cycle.
REQ-009 MemWE  output  1  instruction-memory write strobe, drives the CPU instruction-memory write side.
REQ-010 MemAddr  output  32  instruction-memory byte address.
REQ-011 MemData  output  32  instruction word, drives the CPU Ins_Input.
REQ-012 PC_Value  output  32  CPU start PC.
REQ-013 CpuHold  output  1  holds the CPU in reset while 1.
REQ-014 Busy, Done, Err  output  1 each  session active, session complete, session failed.

Function
REQ-015 SHALL accept a byte only on a cycle with ByteValid=1 and ByteReady=1.
REQ-016 Stream format, big-endian:
- 4 bytes: load address A.
- 2 bytes: word count N.
- N×4 bytes: instruction words.
REQ-017 States SHALL be IDLE, HDR_ADDR, HDR_CNT, PAYLOAD, WRITE, DONE, ERR.
REQ-018 ByteReady SHALL be 1 only in HDR_ADDR, HDR_CNT and PAYLOAD.
REQ-019 Busy SHALL be 1 in HDR_ADDR, HDR_CNT, PAYLOAD and WRITE.
REQ-020 IDLE/DONE/ERR + Start -> HDR_ADDR; SHALL clear Done, Err and all counters. Start SHALL be ignored in other states.
REQ-021 HDR_ADDR -> HDR_CNT after the 4th accepted byte.
- If A[1:0]≠0, SHALL go to ERR instead.
REQ-022 HDR_CNT -> PAYLOAD after the 2nd accepted byte.
- If N=0 or N>WORDS_MAX, SHALL go to ERR instead.
REQ-023 PAYLOAD SHALL shift bytes into a 32-bit assembler, first byte landing in bits [31:24].
- 4th byte accepted at cycle t -> WRITE at t+1.
REQ-024 WRITE SHALL last exactly one cycle:
- MemWE=1, MemData = assembled word, MemAddr = A + 4×k for word index k (0-based); 32-bit wrap-around permitted.
- Then -> PAYLOAD if k+1<N, else DONE.
REQ-025 MemWE SHALL be 0 in every state other than WRITE. MemAddr and MemData SHALL hold their last values.
REQ-026 PC_Value SHALL be updated to A at the transition out of HDR_ADDR, and SHALL hold thereafter until the next valid header.
REQ-027 Output levels per state:
- DONE: Done=1, CpuHold=0.
- All other states: CpuHold=1.
- ERR: Err=1, Done=0.
REQ-028 Abort=1 in any state except IDLE SHALL force ERR on the next edge.
- An in-flight WRITE cycle with Abort still completes its MemWE pulse; the state still goes to ERR.
REQ-029 ByteValid=1 while ByteReady=0 SHALL leave the stream untouched; the byte is not consumed.
REQ-030 Simultaneous Start and Abort in DONE/ERR: Abort SHALL win (-> ERR).

Reset
REQ-031 RST=1 at a clock edge SHALL force the following, overriding all inputs including mid-session:
- State IDLE; counters and assembler 0.
- ByteReady=0, MemWE=0, MemAddr=0, MemData=0, PC_Value=0.
- CpuHold=1, Busy=0, Done=0, Err=0.
REQ-032 RST SHALL take priority over Start and Abort.

Verification
REQ-033 Nominal load:
- Stimulus: Start, then bytes 00 00 01 00 | 00 02 | 02 00 00 08 | 00 00 00 00.
- Required: MemWE pulses at 0x100 with data 0x02000008, and at 0x104 with data 0x00000000.
- Required: PC_Value=0x100; Done=1 and CpuHold=0 one cycle after the second write.
REQ-034 Back-pressure: ByteValid held high continuously -> ByteReady=0 during each WRITE cycle; no byte lost or duplicated, and write data matches the stream.
REQ-035 Header errors:
- Address 00 00 01 02 -> ERR after the 4th byte, no MemWE, Err=1, CpuHold=1.
- Count 00 00 -> ERR.
- Count WORDS_MAX+1 (00 41 at default) -> ERR.
REQ-036 Abort at the 3rd payload byte -> Err=1 on the next cycle, CpuHold=1, no further MemWE; a following Start plus a valid stream completes normally.
REQ-037 RST asserted mid-PAYLOAD -> all outputs at reset values on the next edge; the next Start begins a fresh header parse.
REQ-038 Address wrap: A=0xFFFFFFFC, N=2 -> writes at 0xFFFFFFFC, then at 0x00000000.
